// File: rtl/fproc_responder_if.sv
// fproc_responder_if
//   Core <-> fproc responder request/response bundle.
//   core_req      : per-core request level, held until that core's fproc_valid
//   core_fproc_id : per-core request id, core i in [i*FPROC_ID_W +: FPROC_ID_W]
//   fproc_data    : response word, broadcast to all cores
//   fproc_valid   : one-hot, one cycle; marks fproc_data for that core
//   master = core side, slave = responder side.
interface fproc_responder_if #(
   parameter int N_CORES    = 4,
   parameter int FPROC_ID_W = 8,
   parameter int DATA_W     = 32
);
   logic [N_CORES-1:0]            core_req;
   logic [N_CORES*FPROC_ID_W-1:0] core_fproc_id;
   logic [DATA_W-1:0]             fproc_data;
   logic [N_CORES-1:0]            fproc_valid;

   modport master (
      output core_req, core_fproc_id,
      input  fproc_data, fproc_valid
   );

   modport slave (
      input  core_req, core_fproc_id,
      output fproc_data, fproc_valid
   );
endinterface

// File: rtl/fproc_responder.sv
// fproc_responder
//   Latches measurement results from the readout channels and answers core
//   fproc requests one at a time, round-robin across cores.
// Ports
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   bus        : fproc_responder_if.slave (core_req/core_fproc_id in,
//                fproc_data/fproc_valid out)
//   meas_in    : measurement result bits
//   meas_valid : per-channel strobe latching meas_in[k]
//   busy       : high while a request is in service
// Build option
//   FPROC_WAIT_FRESH_EN : a single-channel read of a channel with no fresh
//                         result waits in WAIT_MEAS until one arrives.
//
// state     | meaning
// IDLE      | arbitrating; grant registers core index and id
// LOOKUP    | decode id, respond or (optionally) wait for a fresh result
// WAIT_MEAS | single-channel read stalled on fresh[id] (option only)
// RESPOND   | fproc_valid/fproc_data presented for one cycle
module fproc_responder #(
   parameter int N_CORES    = 4,
   parameter int N_MEAS     = 8,
   parameter int FPROC_ID_W = 8,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rstn,
   fproc_responder_if.slave  bus,
   input  logic [N_MEAS-1:0] meas_in,
   input  logic [N_MEAS-1:0] meas_valid,
   output logic              busy
);
   localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int MEAS_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOOKUP    = 2'd1,
`ifdef FPROC_WAIT_FRESH_EN
      WAIT_MEAS = 2'd2,
`endif
      RESPOND   = 2'd3
   } state_t;

   state_t              state;
   logic [CORE_W-1:0]   rr_ptr, grant_reg, grant_idx, grant_next_ptr;
   logic                grant_found;
   logic [FPROC_ID_W-1:0] id_reg;
   logic [N_MEAS-1:0]   meas_reg, fresh, fresh_next;
   logic [N_CORES-1:0]  cooldown, eligible;
   logic                id_single, id_vector, ch_ready, bypass, single_bit, fire;
   logic [MEAS_W-1:0]   ch;
   logic [DATA_W-1:0]   resp_data;
   int                  j;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      eligible    = bus.core_req & ~cooldown;
      grant_found = 1'b0;
      grant_idx   = '0;
      j           = 0;
      for (int k = 0; k < N_CORES; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N_CORES) j = j - N_CORES;
         if (!grant_found && eligible[j]) begin
            grant_found = 1'b1;
            grant_idx   = CORE_W'(j);
         end
      end
      grant_next_ptr = (int'(grant_idx) == N_CORES - 1) ? '0 : grant_idx + 1'b1;
   end

   always_comb begin
      id_single = (id_reg < FPROC_ID_W'(N_MEAS));
      id_vector = &id_reg;
      ch        = id_reg[MEAS_W-1:0];
`ifdef FPROC_WAIT_FRESH_EN
      ch_ready  = fresh[ch] | meas_valid[ch];
      // A strobe landing while we wait is forwarded straight from meas_in.
      bypass    = ~fresh[ch] & meas_valid[ch];
`else
      ch_ready  = 1'b1;
      bypass    = 1'b0;
`endif
      single_bit = bypass ? meas_in[ch] : meas_reg[ch];
      resp_data  = '0;
      if (id_single)      resp_data = DATA_W'(single_bit);
      else if (id_vector) resp_data = DATA_W'(meas_reg);

      fire = (state == LOOKUP) && (!id_single || ch_ready);
`ifdef FPROC_WAIT_FRESH_EN
      if ((state == WAIT_MEAS) && ch_ready) fire = 1'b1;
`endif

      // Consuming an older result while a new strobe arrives keeps the new
      // one fresh; a bypassed strobe is itself the result being consumed.
      fresh_next = fresh | meas_valid;
      if (fire && id_single) begin
         if (bypass) fresh_next[ch] = 1'b0;
         else        fresh_next[ch] = meas_valid[ch];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         grant_reg       <= '0;
         id_reg          <= '0;
         meas_reg        <= '0;
         fresh           <= '0;
         cooldown        <= '0;
         busy            <= 1'b0;
         bus.fproc_valid <= '0;
         bus.fproc_data  <= '0;
      end else begin
         meas_reg        <= (meas_reg & ~meas_valid) | (meas_in & meas_valid);
         fresh           <= fresh_next;
         cooldown        <= '0;
         bus.fproc_valid <= '0;
         if (fire) begin
            bus.fproc_valid <= N_CORES'(1) << grant_reg;
            bus.fproc_data  <= resp_data;
         end
         case (state)
            IDLE: begin
               if (grant_found) begin
                  grant_reg <= grant_idx;
                  id_reg    <= bus.core_fproc_id[grant_idx*FPROC_ID_W +: FPROC_ID_W];
                  rr_ptr    <= grant_next_ptr;
                  busy      <= 1'b1;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
`ifdef FPROC_WAIT_FRESH_EN
               state <= fire ? RESPOND : WAIT_MEAS;
`else
               state <= RESPOND;
`endif
            end
`ifdef FPROC_WAIT_FRESH_EN
            WAIT_MEAS: begin
               if (fire) state <= RESPOND;
            end
`endif
            RESPOND: begin
               // Masks the served core for the cycle it takes to drop its req.
               cooldown <= bus.fproc_valid;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fproc_responder.sv
module tb_fproc_responder;
   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] meas_in;
   logic [7:0] meas_valid;
   logic       busy;

   fproc_responder_if #(.N_CORES(4), .FPROC_ID_W(8), .DATA_W(32)) bus ();

   fproc_responder #(.N_CORES(4), .N_MEAS(8), .FPROC_ID_W(8), .DATA_W(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus        (bus),
      .meas_in    (meas_in),
      .meas_valid (meas_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t sbq[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic expect_resp(input logic [3:0] v, input logic [31:0] d, input int at);
      exp_t e;
      e.v = v;
      e.d = d;
      e.c = at;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rstn && bus.fproc_valid != 4'b0) begin
         n_tests++;
         if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected: valid=%b data=%h cyc=%0d", bus.fproc_valid, bus.fproc_data, cyc);
         end else begin
            e = sbq.pop_front();
            if (bus.fproc_valid !== e.v || bus.fproc_data !== e.d || cyc != e.c) begin
               n_fail++;
               $display("FAIL resp: got valid=%b data=%h cyc=%0d, expected valid=%b data=%h cyc=%0d",
                        bus.fproc_valid, bus.fproc_data, cyc, e.v, e.d, e.c);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to the next negedge; strobes are one cycle, and a core drops its
   // request once it sees its valid.
   task automatic tick();
      @(negedge clk);
      meas_valid   = '0;
      bus.core_req = bus.core_req & ~bus.fproc_valid;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_id(input int i, input logic [7:0] id);
      bus.core_fproc_id[i*8 +: 8] = id;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rstn              = 1'b0;
      meas_in           = '0;
      meas_valid        = '0;
      bus.core_req      = '0;
      bus.core_fproc_id = '0;
      ticks(3);
      check("reset_data", bus.fproc_data, 32'h0);
      check("reset_valid", {28'h0, bus.fproc_valid}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      rstn = 1'b1;
      tick();

      // Single-channel read of ch3.
      meas_in = 8'h08; meas_valid = 8'h08;
      tick();
      bus.core_req[0] = 1'b1; set_id(0, 8'd3);
      expect_resp(4'b0001, 32'h1, cyc + 2);
      tick();
      check("busy_lookup", {31'h0, busy}, 32'h1);
      ticks(3);
      check("busy_idle", {31'h0, busy}, 32'h0);

      // Vector / unmapped / single reads with meas_reg = A5.
      meas_in = 8'hA5; meas_valid = 8'hFF;
      tick();
      bus.core_req[2] = 1'b1; set_id(2, 8'hFF);
      expect_resp(4'b0100, 32'h000000A5, cyc + 2);
      ticks(4);
      check("data_hold", bus.fproc_data, 32'h000000A5);
      bus.core_req[2] = 1'b1; set_id(2, 8'h20);
      expect_resp(4'b0100, 32'h0, cyc + 2);
      ticks(4);
      bus.core_req[3] = 1'b1; set_id(3, 8'd7);
      expect_resp(4'b1000, 32'h1, cyc + 2);
      ticks(4);

      // All four cores at once, rr_ptr back at 0.
      set_id(0, 8'hFF); set_id(1, 8'd2); set_id(2, 8'd1); set_id(3, 8'h08);
      bus.core_req = 4'b1111;
      expect_resp(4'b0001, 32'h000000A5, cyc + 2);
      expect_resp(4'b0010, 32'h1, cyc + 5);
      expect_resp(4'b0100, 32'h0, cyc + 8);
      expect_resp(4'b1000, 32'h0, cyc + 11);
      ticks(13);

      // rr_ptr wrapped to 0: core0 before core1.
      set_id(0, 8'd0); set_id(1, 8'd6);
      bus.core_req = 4'b0011;
      expect_resp(4'b0001, 32'h1, cyc + 2);
      expect_resp(4'b0010, 32'h0, cyc + 5);
      ticks(7);

      // Request withdrawn mid-service still answered.
      bus.core_req[3] = 1'b1; set_id(3, 8'd4);
      expect_resp(4'b1000, 32'h0, cyc + 2);
      tick();
      bus.core_req[3] = 1'b0;
      ticks(3);

      // Reset during RESPOND.
      bus.core_req[0] = 1'b1; set_id(0, 8'hFF);
      expect_resp(4'b0001, 32'h000000A5, cyc + 2);
      ticks(2);
      #2;
      rstn = 1'b0;
      bus.core_req = '0;
      #1;
      check("rst_mid_valid", {28'h0, bus.fproc_valid}, 32'h0);
      check("rst_mid_busy", {31'h0, busy}, 32'h0);
      check("rst_mid_data", bus.fproc_data, 32'h0);
      ticks(2);
      rstn = 1'b1;
      tick();
      bus.core_req[0] = 1'b1; set_id(0, 8'hFF);
      expect_resp(4'b0001, 32'h0, cyc + 2);
      ticks(4);

      // Consume of ch2 coinciding with a new ch2 strobe; re-request is served at once.
      meas_in = 8'h04; meas_valid = 8'h04;
      tick();
      bus.core_req[0] = 1'b1; set_id(0, 8'd2);
      expect_resp(4'b0001, 32'h1, cyc + 2);
      tick();
      meas_in = 8'h00; meas_valid = 8'h04;
      ticks(3);
      bus.core_req[0] = 1'b1; set_id(0, 8'd2);
      expect_resp(4'b0001, 32'h0, cyc + 2);
      ticks(4);

`ifdef FPROC_WAIT_FRESH_EN
      // Stall on a channel with no fresh result, released by a strobe.
      bus.core_req[1] = 1'b1; set_id(1, 8'd5);
      ticks(20);
      check("busy_wait", {31'h0, busy}, 32'h1);
      meas_in = 8'h20; meas_valid = 8'h20;
      expect_resp(4'b0010, 32'h1, cyc + 1);
      ticks(3);
      check("busy_after_wait", {31'h0, busy}, 32'h0);
      bus.core_req[1] = 1'b1; set_id(1, 8'd5);
      ticks(5);
      check("busy_rewait", {31'h0, busy}, 32'h1);
      meas_in = 8'h00; meas_valid = 8'h20;
      expect_resp(4'b0010, 32'h0, cyc + 1);
      ticks(3);
`endif

      ticks(3);
      check("scoreboard_drained", sbq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
